// File: rtl/vx_task_warp_sched.sv
// Warp allocator for extended warp spawn: scans the free bitmap, reserves warps for a task and holds the grant.
// Optional macro TASK_SCHED_PERF_EN adds perf_grants / perf_wait_cycles / perf_partial counters.
module vx_task_warp_sched #(
  parameter int unsigned NUM_WARPS = 8,
  parameter logic [NUM_WARPS-1:0] RESET_BUSY_MASK = NUM_WARPS'(1),
  localparam int unsigned NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int unsigned CNTW = $clog2(NUM_WARPS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_WIDTH-1:0]  req_wid,
  input  logic [CNTW-1:0]      req_count,
  output logic                 grant_valid,
  input  logic                 grant_ack,
  output logic [NUM_WARPS-1:0] task_warp_mask,
  output logic [CNTW-1:0]      grant_count,
  input  logic                 release_valid,
  input  logic [NUM_WARPS-1:0] release_wmask,
  output logic [CNTW-1:0]      free_count
`ifdef TASK_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_grants,
  output logic [31:0]          perf_wait_cycles,
  output logic [31:0]          perf_partial
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  function automatic logic [CNTW-1:0] popcnt(input logic [NUM_WARPS-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) n = n + CNTW'(v[i]);
    return n;
  endfunction

  state_e                state_q, state_d;
  logic [NW_WIDTH-1:0]   wid_q, wid_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [NW_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]       picked_q, picked_d;
  logic [NUM_WARPS-1:0]  mask_q, mask_d;
  logic [NUM_WARPS-1:0]  free_q, free_d;
  logic [CNTW-1:0]       free_count_q, free_count_d;

  logic [NUM_WARPS-1:0]  wid_onehot, ptr_onehot, wid_guard, release_eff, pick_bit;
  logic [CNTW-1:0]       picked_inc, count_clamped;

  always_comb begin
    state_d      = state_q;
    wid_d        = wid_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    picked_d     = picked_q;
    mask_d       = mask_q;
    pick_bit     = '0;
    picked_inc   = picked_q;
    wid_onehot   = '0;
    ptr_onehot   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      wid_onehot[i] = (wid_q == NW_WIDTH'(i));
      ptr_onehot[i] = (ptr_q == NW_WIDTH'(i));
    end
    // The latched requester is only protected while a request is in flight
    wid_guard     = (state_q != ST_IDLE) ? wid_onehot : '0;
    release_eff   = release_valid ? (release_wmask & ~mask_q & ~wid_guard) : '0;
    count_clamped = (req_count > CNTW'(NUM_WARPS - 1)) ? CNTW'(NUM_WARPS - 1) : req_count;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wid_d    = req_wid;
          count_d  = count_clamped;
          ptr_d    = '0;
          picked_d = '0;
          mask_d   = '0;
          state_d  = (count_clamped == '0) ? ST_GRANT : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (free_q[ptr_q] && (ptr_q != wid_q)) begin
          pick_bit   = ptr_onehot;
          picked_inc = picked_q + CNTW'(1);
        end
        picked_d = picked_inc;
        mask_d   = mask_q | pick_bit;
        if ((picked_inc == count_q) || (ptr_q == NW_WIDTH'(NUM_WARPS - 1))) begin
          state_d = (picked_inc != '0) ? ST_GRANT : ST_WAIT;
        end else begin
          ptr_d = ptr_q + NW_WIDTH'(1);
        end
      end
      ST_WAIT: begin
        if (release_valid) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_GRANT: begin
        if (grant_ack) begin
          state_d  = ST_IDLE;
          mask_d   = '0;
          picked_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reservation wins over a same-cycle release of the same bit
    free_d       = (free_q | release_eff) & ~pick_bit;
    free_count_d = popcnt(free_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wid_q        <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      picked_q     <= '0;
      mask_q       <= '0;
      free_q       <= ~RESET_BUSY_MASK;
      free_count_q <= popcnt(~RESET_BUSY_MASK);
    end else begin
      state_q      <= state_d;
      wid_q        <= wid_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      picked_q     <= picked_d;
      mask_q       <= mask_d;
      free_q       <= free_d;
      free_count_q <= free_count_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign grant_valid    = (state_q == ST_GRANT);
  assign task_warp_mask = mask_q;
  assign grant_count    = picked_q;
  assign free_count     = free_count_q;

  release_of_busy_warp : assert property (@(posedge clk) disable iff (!reset)
    release_valid |-> ((release_wmask & (mask_q | wid_guard)) == '0));

`ifdef TASK_SCHED_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_partial_q, perf_partial_d;

  always_comb begin
    perf_grants_d  = perf_grants_q;
    perf_wait_d    = perf_wait_q;
    perf_partial_d = perf_partial_q;
    if ((state_q == ST_GRANT) && grant_ack) begin
      perf_grants_d = perf_grants_q + 32'd1;
      if (picked_q < count_q) perf_partial_d = perf_partial_q + 32'd1;
    end
    if (state_q == ST_WAIT) perf_wait_d = perf_wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_grants_q  <= '0;
      perf_wait_q    <= '0;
      perf_partial_q <= '0;
    end else begin
      perf_grants_q  <= perf_grants_d;
      perf_wait_q    <= perf_wait_d;
      perf_partial_q <= perf_partial_d;
    end
  end

  assign perf_grants      = perf_grants_q;
  assign perf_wait_cycles = perf_wait_q;
  assign perf_partial     = perf_partial_q;
`endif

endmodule

// File: tb/tb_vx_task_warp_sched.sv
// Scoreboard bench for vx_task_warp_sched (NUM_WARPS=8): model predicts grant mask, count and cycle.
module tb_vx_task_warp_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_wid = '0;
  logic [3:0] req_count = '0;
  logic       grant_valid;
  logic       grant_ack = 1'b0;
  logic [7:0] task_warp_mask;
  logic [3:0] grant_count;
  logic       release_valid = 1'b0;
  logic [7:0] release_wmask = '0;
  logic [3:0] free_count;
`ifdef TASK_SCHED_PERF_EN
  logic [31:0] perf_grants, perf_wait_cycles, perf_partial;
`endif

  vx_task_warp_sched #(.NUM_WARPS(8), .RESET_BUSY_MASK(8'h01)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_count(req_count),
    .grant_valid(grant_valid), .grant_ack(grant_ack),
    .task_warp_mask(task_warp_mask), .grant_count(grant_count),
    .release_valid(release_valid), .release_wmask(release_wmask),
    .free_count(free_count)
`ifdef TASK_SCHED_PERF_EN
    , .perf_grants(perf_grants), .perf_wait_cycles(perf_wait_cycles), .perf_partial(perf_partial)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] mask;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         grants_seen = 0;
  logic       prev_gv = 1'b0;
  logic [7:0] held_mask;
  logic [3:0] held_cnt;
  logic [7:0] model_free;
  int         acks = 0;
  int         partials = 0;
  int         wait_cycles = 0;
  bit         last_partial;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every grant against the scoreboard and holds it stable while presented
  always @(negedge clk) begin
    if (!reset) begin
      prev_gv = 1'b0;
    end else begin
      if (grant_valid && !prev_gv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got mask 0x%0h with nothing expected", task_warp_mask);
        end else begin
          mon_e = sb.pop_front();
          chk("grant_mask", task_warp_mask, mon_e.mask);
          chk("grant_count", grant_count, mon_e.cnt);
          chk("grant_cycle", cyc, mon_e.cyc);
        end
        held_mask = task_warp_mask;
        held_cnt  = grant_count;
        grants_seen++;
      end else if (grant_valid) begin
        chk("mask_stable", task_warp_mask, held_mask);
        chk("count_stable", grant_count, held_cnt);
        chk("ready_low_in_grant", req_ready, 0);
      end
      prev_gv = grant_valid;
    end
  end

  // Reference: first free warps in index order, skipping the requester, up to min(count,7)
  task automatic predict(input int wid, input int cnt, input int t, output bit waiting);
    int         cl;
    int         p;
    int         last;
    logic [7:0] m;
    exp_t       e;
    cl = (cnt > 7) ? 7 : cnt;
    p = 0;
    last = 0;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (p < cl && model_free[i] && i != wid) begin
        m[i] = 1'b1;
        p++;
        last = i;
      end
    end
    waiting = 1'b0;
    if (cl != 0 && p == 0) begin
      waiting = 1'b1;
      return;
    end
    e.mask = m;
    e.cnt  = p;
    if (cl == 0) e.cyc = t + 1;
    else if (p == cl) e.cyc = t + 2 + last;
    else e.cyc = t + 2 + 7;
    last_partial = (p < cl);
    model_free = model_free & ~m;
    sb.push_back(e);
  endtask

  task automatic idle_release(input logic [7:0] m);
    @(negedge clk);
    release_valid = 1'b1;
    release_wmask = m;
    @(posedge clk);
    model_free = model_free | m;
    @(negedge clk);
    release_valid = 1'b0;
    release_wmask = '0;
  endtask

  task automatic wait_grant(input int start);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (grants_seen > start) begin
        got = 1'b1;
        break;
      end
      grant_ack = 1'($urandom % 2);
    end
    grant_ack = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected one within 60 cycles");
    end
  endtask

  task automatic do_txn(input int wid, input int cnt, input logic [7:0] wait_rel,
                        input logic [7:0] scan_rel, input int hold);
    int         t;
    int         r;
    int         start;
    bit         waiting;
    logic [7:0] rel;
    logic [7:0] cand;
    repeat (2) @(negedge clk);
    chk("free_count", free_count, $countones(model_free));
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_wid   = 3'(wid);
    req_count = 4'(cnt);
    start     = grants_seen;
    @(posedge clk);
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    predict(wid, cnt, t, waiting);
    if (scan_rel != '0) begin
      repeat (6) @(posedge clk);
      @(negedge clk);
      release_valid = 1'b1;
      release_wmask = scan_rel;
      @(posedge clk);
      model_free = model_free | scan_rel;
      @(negedge clk);
      release_valid = 1'b0;
      release_wmask = '0;
    end
    if (waiting) begin
      repeat (10 + $urandom_range(0, 3)) @(negedge clk);
      chk("wait_no_grant", grant_valid, 0);
      chk("wait_not_ready", req_ready, 0);
      cand = ~model_free & ~(8'h01 << wid);
      rel  = wait_rel;
      if (rel == '0) rel = 8'($urandom) & cand;
      if (rel == '0) rel = cand & (~cand + 8'h01);
      release_valid = 1'b1;
      release_wmask = rel;
      @(posedge clk);
      r = cyc;
      wait_cycles += r - t - 8;
      model_free = model_free | rel;
      @(negedge clk);
      release_valid = 1'b0;
      release_wmask = '0;
      predict(wid, cnt, r, waiting);
    end
    wait_grant(start);
    repeat (hold) @(negedge clk);
    grant_ack = 1'b1;
    @(posedge clk);
    acks++;
    if (last_partial) partials++;
    @(negedge clk);
    grant_ack = 1'b0;
    chk("ack_grant_low", grant_valid, 0);
    chk("ack_mask_clear", task_warp_mask, 0);
    chk("ack_count_clear", grant_count, 0);
    chk("ack_ready", req_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    model_free = 8'hFE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("reset_free_count", free_count, 7);
    chk("reset_ready", req_ready, 1);
    chk("reset_grant_valid", grant_valid, 0);
    chk("reset_mask", task_warp_mask, 0);
    chk("reset_grant_count", grant_count, 0);

    do_txn(0, 3, 8'h00, 8'h00, 10);   // 0x0E at T+5
    do_txn(0, 4, 8'h00, 8'h00, 1);    // takes 0xF0, pool empty
    do_txn(1, 2, 8'h40, 8'h00, 1);    // WAIT, then partial 0x40
    do_txn(2, 0, 8'h00, 8'h00, 2);    // empty grant at T+1
    idle_release(8'hF7);
    do_txn(3, 9, 8'h00, 8'h00, 0);    // clamped to 7, warp 3 excluded
    idle_release(8'h80);
    do_txn(0, 2, 8'h00, 8'h20, 2);    // warp 5 released behind the scan pointer
    do_txn(0, 1, 8'h00, 8'h00, 1);    // warp 5 now granted

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) idle_release(8'($urandom) & ~model_free);
      do_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), 8'h00, 8'h00,
             int'($urandom_range(0, 4)));
    end

`ifdef TASK_SCHED_PERF_EN
    @(negedge clk);
    chk("perf_grants", perf_grants, acks);
    chk("perf_partial", perf_partial, partials);
    chk("perf_wait_cycles", perf_wait_cycles, wait_cycles);
`endif

    // Reset while scanning drops the reservation and restores the boot pool
    idle_release(~model_free);
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    req_wid   = 3'd0;
    req_count = 4'd7;
    @(posedge clk);
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_free = 8'hFE;
    chk("midreset_mask", task_warp_mask, 0);
    chk("midreset_grant_valid", grant_valid, 0);
    chk("midreset_ready", req_ready, 1);
    chk("midreset_free_count", free_count, 7);
    do_txn(0, 3, 8'h00, 8'h00, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
